// File: rtl/p251_mul_arb_if.sv
// Request/response bundle for the shared mod-251 multiplier: two requester
// channels with valid/ready handshake and two strobe-only response channels.
interface p251_mul_arb_if #(
    parameter int TAG_W = 4
);
    logic             i_req0_valid;
    logic             i_req1_valid;
    logic             o_req0_ready;
    logic             o_req1_ready;
    logic [7:0]       i_req0_a;
    logic [7:0]       i_req0_b;
    logic [7:0]       i_req1_a;
    logic [7:0]       i_req1_b;
    logic [TAG_W-1:0] i_req0_tag;
    logic [TAG_W-1:0] i_req1_tag;
    logic             o_rsp0_valid;
    logic             o_rsp1_valid;
    logic [7:0]       o_rsp0_c;
    logic [7:0]       o_rsp1_c;
    logic [TAG_W-1:0] o_rsp0_tag;
    logic [TAG_W-1:0] o_rsp1_tag;
    logic             o_busy;

    modport slave (
        input  i_req0_valid, i_req1_valid,
        input  i_req0_a, i_req0_b, i_req1_a, i_req1_b,
        input  i_req0_tag, i_req1_tag,
        output o_req0_ready, o_req1_ready,
        output o_rsp0_valid, o_rsp1_valid,
        output o_rsp0_c, o_rsp1_c,
        output o_rsp0_tag, o_rsp1_tag,
        output o_busy
    );

    modport master (
        output i_req0_valid, i_req1_valid,
        output i_req0_a, i_req0_b, i_req1_a, i_req1_b,
        output i_req0_tag, i_req1_tag,
        input  o_req0_ready, o_req1_ready,
        input  o_rsp0_valid, o_rsp1_valid,
        input  o_rsp0_c, o_rsp1_c,
        input  o_rsp0_tag, o_rsp1_tag,
        input  o_busy
    );
endinterface

// File: rtl/p251_mul_arb.sv
// Two-requester arbiter sharing one 8x8 multiplier and mod-251 reducer, 2-stage pipeline.
// Define P251_MUL_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module p251_mul_arb #(
    parameter int TAG_W = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    p251_mul_arb_if.slave   bus
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic             accept;
    logic             accept_id;
    logic             contention_pick;
    logic [7:0]       op_a;
    logic [7:0]       op_b;
    logic [TAG_W-1:0] op_tag;
    logic [15:0]      product;

    logic             s1_valid_reg;
    logic             s1_id_reg;
    logic [TAG_W-1:0] s1_tag_reg;
    logic [15:0]      s1_prod_reg;

    logic [10:0]      fold1;
    logic [8:0]       fold2;
    logic [7:0]       reduced;

    assign req_valid = {bus.i_req1_valid, bus.i_req0_valid};

`ifdef P251_MUL_ARB_RR_EN
    // Pointer holds the id of the last accepted requester; contention goes to the other one.
    logic last_grant_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_grant_reg <= 1'b1;
        end else if (accept) begin
            last_grant_reg <= accept_id;
        end
    end

    assign contention_pick = ~last_grant_reg;
`else
    assign contention_pick = 1'b0;
`endif

    always_comb begin
        req_ready = 2'b00;
        if (i_rst_n) begin
            if (req_valid == 2'b11) begin
                req_ready = contention_pick ? 2'b10 : 2'b01;
            end else begin
                req_ready = req_valid;
            end
        end
    end

    assign bus.o_req0_ready = req_ready[0];
    assign bus.o_req1_ready = req_ready[1];
    assign accept    = |req_ready;
    assign accept_id = req_ready[1];

    assign op_a   = accept_id ? bus.i_req1_a   : bus.i_req0_a;
    assign op_b   = accept_id ? bus.i_req1_b   : bus.i_req0_b;
    assign op_tag = accept_id ? bus.i_req1_tag : bus.i_req0_tag;
    assign product = op_a * op_b;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= accept;
        end
    end

    // Payload needs no reset: it is only observed when the valid bit says so.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            s1_id_reg   <= accept_id;
            s1_tag_reg  <= op_tag;
            s1_prod_reg <= product;
        end
    end

    // 256 == 5 (mod 251): fold the high byte twice, then one conditional subtract.
    // fold1 <= 5*254+255 = 1525, fold2 <= 5*5+255 = 280 < 2*251.
    assign fold1   = 11'(s1_prod_reg[15:8]) * 11'd5 + 11'(s1_prod_reg[7:0]);
    assign fold2   = 9'(fold1[10:8]) * 9'd5 + 9'(fold1[7:0]);
    assign reduced = (fold2 >= 9'd251) ? 8'(fold2 - 9'd251) : fold2[7:0];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic             hit;
            logic             v_reg;
            logic [7:0]       c_reg;
            logic [TAG_W-1:0] tag_reg;

            assign hit = s1_valid_reg && (s1_id_reg == 1'(gi));

            // Per-channel S2: result and tag persist until this channel's next result.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    v_reg   <= 1'b0;
                    c_reg   <= 8'd0;
                    tag_reg <= '0;
                end else begin
                    v_reg <= hit;
                    if (hit) begin
                        c_reg   <= reduced;
                        tag_reg <= s1_tag_reg;
                    end
                end
            end
        end
    endgenerate

    assign bus.o_rsp0_valid = g_ch[0].v_reg;
    assign bus.o_rsp0_c     = g_ch[0].c_reg;
    assign bus.o_rsp0_tag   = g_ch[0].tag_reg;
    assign bus.o_rsp1_valid = g_ch[1].v_reg;
    assign bus.o_rsp1_c     = g_ch[1].c_reg;
    assign bus.o_rsp1_tag   = g_ch[1].tag_reg;

    assign bus.o_busy = s1_valid_reg | g_ch[0].v_reg | g_ch[1].v_reg;
endmodule

// File: tb/tb_p251_mul_arb.sv
// Bench for p251_mul_arb: queue-based reference model checked every negedge,
// plus directed vectors with literal expected results and grant sequences.
module tb_p251_mul_arb;
    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    p251_mul_arb_if #(.TAG_W(TAG_W)) bus ();
    p251_mul_arb #(.TAG_W(TAG_W)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    typedef struct {
        int ch;
        int c;
        int tag;
        int due;
        int lit;
    } ent_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   lit0 = -1;
    int   lit1 = -1;
    int   acc_log [4096];
    ent_t q [$];
    int   last_c [2];
    int   last_tag [2];
    int   last_grant = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Reference model: results due two cycles after acceptance, in order.
    always @(negedge clk) begin : cmp
        int   ev [2];
        int   r0;
        int   r1;
        ent_t e;
        if (!rst_n) begin
            q.delete();
            last_c     = '{0, 0};
            last_tag   = '{0, 0};
            last_grant = 1;
            acc_log[cyc] = -1;
            chk("rst_ready0", bus.o_req0_ready, 0);
            chk("rst_ready1", bus.o_req1_ready, 0);
            chk("rst_rsp0_valid", bus.o_rsp0_valid, 0);
            chk("rst_rsp1_valid", bus.o_rsp1_valid, 0);
            chk("rst_rsp0_c", bus.o_rsp0_c, 0);
            chk("rst_rsp1_c", bus.o_rsp1_c, 0);
            chk("rst_rsp0_tag", bus.o_rsp0_tag, 0);
            chk("rst_rsp1_tag", bus.o_rsp1_tag, 0);
            chk("rst_busy", bus.o_busy, 0);
        end else begin
            chk("busy", bus.o_busy, int'(q.size() != 0));
            ev = '{0, 0};
            if (q.size() != 0 && q[0].due == cyc) begin
                e = q.pop_front();
                ev[e.ch]       = 1;
                last_c[e.ch]   = e.c;
                last_tag[e.ch] = e.tag;
                if (e.lit >= 0) begin
                    if (e.ch == 1) chk("lit_c1", bus.o_rsp1_c, e.lit);
                    else           chk("lit_c0", bus.o_rsp0_c, e.lit);
                end
            end
            chk("rsp0_valid", bus.o_rsp0_valid, ev[0]);
            chk("rsp1_valid", bus.o_rsp1_valid, ev[1]);
            chk("rsp0_c", bus.o_rsp0_c, last_c[0]);
            chk("rsp1_c", bus.o_rsp1_c, last_c[1]);
            chk("rsp0_tag", bus.o_rsp0_tag, last_tag[0]);
            chk("rsp1_tag", bus.o_rsp1_tag, last_tag[1]);

            r0 = 0;
            r1 = 0;
            if (bus.i_req0_valid && bus.i_req1_valid) begin
`ifdef P251_MUL_ARB_RR_EN
                if (last_grant == 1) r0 = 1;
                else                 r1 = 1;
`else
                r0 = 1;
`endif
            end else begin
                r0 = int'(bus.i_req0_valid);
                r1 = int'(bus.i_req1_valid);
            end
            chk("ready0", bus.o_req0_ready, r0);
            chk("ready1", bus.o_req1_ready, r1);

            acc_log[cyc] = (bus.i_req0_valid && bus.o_req0_ready) ? 0 :
                           (bus.i_req1_valid && bus.o_req1_ready) ? 1 : -1;

            if (r0 != 0 || r1 != 0) begin
                e.ch  = r1;
                e.due = cyc + 2;
                if (r1 != 0) begin
                    e.c   = (int'(bus.i_req1_a) * int'(bus.i_req1_b)) % 251;
                    e.tag = int'(bus.i_req1_tag);
                    e.lit = lit1;
                end else begin
                    e.c   = (int'(bus.i_req0_a) * int'(bus.i_req0_b)) % 251;
                    e.tag = int'(bus.i_req0_tag);
                    e.lit = lit0;
                end
                q.push_back(e);
                last_grant = r1;
            end
        end
    end

    task automatic drive(input int v0, input int a0, input int b0, input int t0, input int l0,
                         input int v1, input int a1, input int b1, input int t1, input int l1);
        bus.i_req0_valid = v0[0];
        bus.i_req0_a     = a0[7:0];
        bus.i_req0_b     = b0[7:0];
        bus.i_req0_tag   = t0[TAG_W-1:0];
        bus.i_req1_valid = v1[0];
        bus.i_req1_a     = a1[7:0];
        bus.i_req1_b     = b1[7:0];
        bus.i_req1_tag   = t1[TAG_W-1:0];
        lit0 = l0;
        lit1 = l1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, -1, 0, 0, 0, 0, -1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int start;
        int exp_seq [4];
        int a;
        int b;
        int t;

        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;
        bus.i_req0_a = '0; bus.i_req0_b = '0; bus.i_req0_tag = '0;
        bus.i_req1_a = '0; bus.i_req1_b = '0; bus.i_req1_tag = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Single requester, max in-field operands: 250*250 = 62500 = 249*251 + 1
        drive(1, 250, 250, 3, 1, 0, 0, 0, 0, -1);
        idle(4);

        // Out-of-field operands on requester 1, back to back
        drive(0, 0, 0, 0, -1, 1, 255, 255, 9, 16);
        drive(0, 0, 0, 0, -1, 1, 251, 1, 10, 0);
        drive(0, 0, 0, 0, -1, 1, 0, 77, 11, 0);
        drive(0, 0, 0, 0, -1, 1, 2, 3, 12, 6);
        idle(4);

        // Contention for 4 cycles; requester 1 was granted last
`ifdef P251_MUL_ARB_RR_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        start = cyc;
        drive(1, 10, 20, 1, 200, 1, 30, 40, 2, 196);
        drive(1, 11, 21, 3, 231, 1, 31, 41, 4, 16);
        drive(1, 12, 22, 5, 13, 1, 32, 42, 6, 89);
        drive(1, 13, 23, 7, 48, 1, 33, 43, 8, 164);
        idle(4);
        for (int i = 0; i < 4; i++) chk("contention_grant", acc_log[start + i], exp_seq[i]);

        // Reset mid-flight: req1 then req0 accepted, reset one cycle later
        drive(0, 0, 0, 0, -1, 1, 7, 9, 5, 63);
        drive(1, 11, 13, 6, 143, 0, 0, 0, 0, -1);
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_rst_busy", bus.o_busy, 0);
        idle(3);
        start = cyc;
        drive(1, 5, 6, 1, 30, 1, 7, 8, 2, 56);
        idle(4);
        chk("post_rst_grant", acc_log[start], 0);

        // Back-to-back random stream from requester 0
        for (int i = 0; i < 256; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            t = int'($urandom_range(0, 15));
            drive(1, a, b, t, -1, 0, 0, 0, 0, -1);
        end
        bus.i_req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("stream_busy_s2", bus.o_busy, 1);
        @(negedge clk);
        chk("stream_busy_fall", bus.o_busy, 0);
        @(posedge clk);
        #1;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/p251_mul_arb.md
P251_MUL_ARB -- requirements
Module: p251_mul_arb

Interface
REQ-001 SHALL have parameter TAG_W, default 4, width of the requester tag echoed with each result.
REQ-002 SHALL have port i_clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports i_req0_valid, i_req1_valid  input  1  operand pair offered by requester 0/1.
REQ-005 SHALL have ports o_req0_ready, o_req1_ready  output  1  grant; the transfer occurs when valid and ready are both high on a clock edge.
REQ-006 SHALL have ports i_req0_a, i_req0_b, i_req1_a, i_req1_b  input  8  operands, any value 0..255.
REQ-007 SHALL have ports i_req0_tag, i_req1_tag  input  TAG_W  opaque tag.
REQ-008 SHALL have ports o_rsp0_valid, o_rsp1_valid  output  1  one-cycle result strobe, no backpressure.
REQ-009 SHALL have ports o_rsp0_c, o_rsp1_c  output  8  (a*b) mod 251.
REQ-010 SHALL have ports o_rsp0_tag, o_rsp1_tag  output  TAG_W  tag of the accepted request.
REQ-011 SHALL have port o_busy  output  1  high while any pipeline stage holds a valid entry.

Function
REQ-012 SHALL contain exactly one 8x8 multiplier and one mod-251 reducer, shared by both requesters.
REQ-013 SHALL form the grant combinationally from the valid inputs and the arbitration state; at most one ready SHALL be high per cycle.
REQ-014 SHALL drive ready low for a requester whose valid is low.
REQ-015 SHALL grant a single active requester immediately, whatever the arbitration state.
REQ-016 SHALL accept one request per cycle with no bubbles: throughput 1 result/cycle.
REQ-017 Stage S1 SHALL register the 16-bit product, the requester id, the tag and a valid bit on acceptance.
REQ-018 Stage S2 SHALL register the reduced result, the id, the tag and a valid bit from S1.
REQ-019 SHALL assert o_rspN_valid exactly 2 cycles after acceptance, on the accepting requester's channel only.
REQ-020 Results SHALL return in acceptance order.
REQ-021 Reduction SHALL be exact for all products 0..65025 and SHALL give a result in 0..250, including operands >= 251.
REQ-022 o_rspN_c and o_rspN_tag SHALL hold their last values when valid is low.
REQ-023 SHALL deassert o_busy only when both S1 and S2 are empty.

Reset
REQ-024 Asserting i_rst_n low SHALL asynchronously clear the S1/S2 valid bits, all rsp outputs (to 0), o_busy, and set the last-grant pointer to 1.
REQ-025 Entries in flight when reset asserts SHALL be discarded, and no o_rsp*_valid SHALL appear after reset deasserts until a new acceptance.
REQ-026 While reset is low, both ready outputs SHALL be 0.

Configuration
REQ-027 With macro P251_MUL_ARB_RR_EN defined, the block SHALL arbitrate round-robin.
- On contention, grant the requester not granted last.
- Update the pointer on every acceptance.
- The first contention after reset goes to requester 0.
REQ-028 Without P251_MUL_ARB_RR_EN, the block SHALL use fixed priority: requester 0 always wins contention, and the pointer logic SHALL be absent.

Verification
REQ-029 Single requester: req0 a=250, b=250, tag=3 accepted at cycle T -> o_rsp0_valid at T+2 with c=1, tag=3; o_rsp1_valid stays 0.
REQ-030 Out-of-field operands: req1 a=255, b=255 -> c=16; a=251, b=1 -> c=0; a=0, b=77 -> c=0; a=2, b=3 -> c=6.
REQ-031 Contention with RR_EN: both valid for 4 cycles -> grants 0,1,0,1; four results on alternating channels at +2 cycles, one per cycle.
REQ-032 Contention without RR_EN: both valid for 4 cycles -> req0 ready all 4 cycles, req1 never ready.
REQ-033 Reset mid-flight: accept 2 requests, assert i_rst_n low one cycle later, release -> no rsp valid, o_busy=0, next contention granted to req0.
REQ-034 Back-to-back stream: 256 random pairs from req0 -> every result matches the (a*b)%251 model in order; o_busy falls 2 cycles after the last acceptance.
